// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, word-addressed instruction memory
// with a debug write port, next-PC selection (JR > J > BEQ > PC+4) and a
// registered IF/ID output carrying a valid bit. A fetched HALT_WORD freezes
// fetch until reset.
module if_fetch_unit #(
  parameter int          IMEM_AW   = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic        i_stall,
  input  logic        i_pcsrc,
  input  logic [31:0] i_beq_dir,
  input  logic        i_jump,
  input  logic [25:0] i_j_index,
  input  logic        i_jumpSel,
  input  logic [31:0] i_jr_jump_addr,
  input  logic        i_write_en,
  input  logic [31:0] i_addr_wr,
  input  logic [31:0] i_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus_4,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_halt
);

  localparam int DEPTH = 2 ** IMEM_AW;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [31:0]        mem_r [DEPTH];
  logic [31:0]        pc_r;
  logic [0:0]         state_r;

  logic [31:0]        pc_inc_s;
  logic [31:0]        next_pc_s;
  logic [31:0]        rd_data_s;
  logic               redirect_s;
  logic               mem_we_s;
  logic [IMEM_AW-1:0] rd_idx_s;
  logic [IMEM_AW-1:0] wr_idx_s;
  logic               unused_addr_bits_s;

  // Addresses beyond the memory depth simply wrap onto the low word index.
  assign rd_idx_s  = pc_r[IMEM_AW+1:2];
  assign wr_idx_s  = i_addr_wr[IMEM_AW+1:2];
  assign rd_data_s = mem_r[rd_idx_s];
  assign pc_inc_s  = pc_r + 32'd4;

  assign redirect_s = i_jumpSel | i_jump | i_pcsrc;
  // A write is suppressed while reset is asserted or the clock enable is low.
  assign mem_we_s   = i_reset & i_clk_en & i_write_en;

  assign unused_addr_bits_s = ^{i_addr_wr[31:IMEM_AW+2], i_addr_wr[1:0]};

  // Next-PC selection with fixed priority JR > J > BEQ > sequential.
  always_comb begin
    next_pc_s = pc_inc_s;
    if (i_jumpSel) begin
      next_pc_s = i_jr_jump_addr & ~32'd3;
    end else if (i_jump) begin
      next_pc_s = {o_pc_plus_4[31:28], i_j_index, 2'b00};
    end else if (i_pcsrc) begin
      next_pc_s = i_beq_dir & ~32'd3;
    end else begin
      next_pc_s = pc_inc_s;
    end
  end

  // Debug loader write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      mem_r[wr_idx_s] <= i_data;
    end
  end

  // PC, run/halt state and registered IF/ID outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc_r          <= RESET_PC & ~32'd3;
      state_r       <= ST_RUN;
      o_valid       <= 1'b0;
      o_instruction <= 32'd0;
      o_pc          <= 32'd0;
      o_pc_plus_4   <= 32'd4;
      o_halt        <= 1'b0;
    end else if (i_clk_en) begin
      case (state_r)
        ST_RUN: begin
          if (i_write_en) begin
            // Loader owns the memory this cycle; any redirect is dropped.
            o_valid <= 1'b0;
          end else if (redirect_s) begin
            // Redirect beats stall: the branch in ID is older than the stalled op.
            pc_r    <= next_pc_s;
            o_valid <= 1'b0;
          end else if (!i_stall) begin
            o_instruction <= rd_data_s;
            o_pc          <= pc_r;
            o_pc_plus_4   <= pc_inc_s;
            o_valid       <= 1'b1;
            if (rd_data_s == HALT_WORD) begin
              state_r <= ST_HALT;
              o_halt  <= 1'b1;
            end else begin
              pc_r <= next_pc_s;
            end
          end
        end
        ST_HALT: begin
          // Halt word is presented once; afterwards the slot stays empty.
          o_valid <= 1'b0;
        end
        default: begin
          state_r <= ST_HALT;
          o_halt  <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised successor to the single-cycle instruction fetch stage. Holds the PC and an instruction memory with a synchronous read port, plus a write port for the debug loader.
- Selects the next PC with fixed priority: JR > J > BEQ > PC+4.
- Drives a registered IF/ID output with a valid bit. Redirects squash the wrong-path slot. A halt word stops fetch.
- Sits between the debug unit/loader and the IF/ID pipeline register feeding ID.

Parameters:
- IMEM_AW, 8: log2 of instruction memory depth in 32-bit words (depth = 2**IMEM_AW).
- RESET_PC, 32'h0000_0000: PC value after reset. Bits [1:0] are ignored (treated as 0).
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts fetch.

Ports:
- i_clk  in  1  clock. All state changes on the rising edge.
- i_reset  in  1  synchronous reset, active-low.
- i_clk_en  in  1  global enable; when 0, all state holds (reset still acts).
- i_stall  in  1  hazard stall from ID; holds the PC and IF/ID output.
- i_pcsrc  in  1  BEQ taken.
- i_beq_dir  in  32  BEQ target.
- i_jump  in  1  J/JAL taken.
- i_j_index  in  26  jump index field of the instruction in ID.
- i_jumpSel  in  1  JR/JALR taken.
- i_jr_jump_addr  in  32  JR target (register value).
- i_write_en  in  1  debug write to the instruction memory.
- i_addr_wr  in  32  byte address of the debug write; word index is i_addr_wr[IMEM_AW+1:2].
- i_data  in  32  debug write data.
- o_pc  out  32  PC of the instruction in o_instruction.
- o_pc_plus_4  out  32  o_pc + 4.
- o_instruction  out  32  fetched instruction.
- o_valid  out  1  o_instruction is a live instruction.
- o_halt  out  1  fetch is halted.

Behaviour:
- Reset (i_reset=0 at an edge):
  - pc_q = RESET_PC & ~3, state = RUN.
  - o_valid = 0, o_instruction = 0, o_pc = 0, o_pc_plus_4 = 4, o_halt = 0.
  - Memory contents are preserved.
- Memory:
  - Word index is pc_q[IMEM_AW+1:2]. Addresses above the depth wrap; no error is raised.
  - Read is synchronous: one-cycle latency from pc_q to o_instruction.
  - A write lands at the edge. A same-cycle read of the same word returns the old data.
- Next PC, evaluated when advancing:
  - i_jumpSel: i_jr_jump_addr & ~3.
  - else i_jump: {o_pc_plus_4[31:28], i_j_index, 2'b00}.
  - else i_pcsrc: i_beq_dir & ~3.
  - else pc_q + 4, 32-bit wrap (FFFF_FFFC -> 0000_0000).
- States:
  - RUN:
    - Each enabled edge with no hold: o_instruction <= mem[pc_q], o_pc <= pc_q, o_pc_plus_4 <= pc_q + 4, o_valid <= 1, pc_q <= next PC.
  - Redirect (any of jumpSel/jump/pcsrc) in RUN:
    - pc_q <= target and o_valid <= 0, squashing the sequential fetch.
    - Exactly one bubble; the target instruction appears with o_valid=1 one cycle later.
    - Redirect has priority over i_stall: the redirecting instruction is older than the stalled one.
  - Stall (i_stall=1, no redirect): pc_q and all o_* hold.
  - Debug write (i_write_en=1):
    - Write is performed. Fetch holds as for a stall, except o_valid <= 0.
    - A redirect arriving in the same cycle is dropped.
  - Halt entry: when RUN latches an instruction equal to HALT_WORD:
    - o_valid <= 1 for that word and pc_q holds at the halt word's address.
    - state -> HALT, o_halt <= 1.
  - HALT:
    - pc_q and o_* hold, except o_valid <= 0 after the first HALT cycle.
    - Redirects and stalls are ignored. Debug writes are still accepted.
    - Exit only via reset.
- i_clk_en=0: nothing changes, including memory writes and state.
- Simultaneous jumpSel, jump and pcsrc: highest priority wins; the others are ignored.
- Reset asserted mid-stall, mid-write or in HALT: reset wins; the write in that cycle is not performed.

Test Plan:
- Load 0x20080005, 0x20090007, 0x01095020 at byte addresses 0, 4, 8 via the write port; release reset -> o_valid=1 with o_pc = 0, 4, 8 on consecutive cycles; o_pc_plus_4 = 4, 8, 12.
- In RUN with o_pc=0x8, assert i_pcsrc for 1 cycle, i_beq_dir=0x40 -> next cycle o_valid=0; following cycle o_pc=0x40, o_instruction=mem[16], o_valid=1.
- Assert i_jumpSel (0x10), i_jump (index 0x3) and i_pcsrc (0x40) together -> fetch resumes at 0x10. Then i_jump alone with index 0x3 -> resumes at 0x0C.
- Hold i_stall 3 cycles at o_pc=0x4 -> o_pc, o_instruction and o_valid unchanged for 3 cycles; pc+4 sequence resumes after release. Stall + i_pcsrc together -> redirect taken.
- Place 0xFFFFFFFF at 0x0C -> o_instruction=FFFFFFFF, o_valid=1, o_halt=1. Next cycles: o_valid=0 and o_pc=0x0C stays fixed despite i_pcsrc pulses. Reset low -> o_halt=0 and fetch restarts at RESET_PC.
- Toggle i_clk_en=0 for 2 cycles mid-run with i_write_en=1 -> no PC change and no memory write (readback of the target word shows the old value).
